// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked EX-stage ALU with multi-cycle multiply and restoring divide
module alu_multicycle #(
  parameter int XLEN         = 32,
  parameter int MUL_LAT      = 2,
  parameter int TAG_W        = 5,
  parameter int DIV_FASTPATH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int CMAX = XLEN > MUL_LAT ? XLEN : MUL_LAT;
  localparam int CW = $clog2(CMAX);
  localparam int SW = $clog2(XLEN);
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3,
    OP_SLTU = 5'd4, OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_OR = 5'd8,
    OP_AND = 5'd9, OP_PASSB = 5'd10, OP_MULH = 5'd17, OP_MULHSU = 5'd18;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0]     cnt;
  logic [1:0]        op_lo;
  logic [2*XLEN-1:0] prod, prod_in;
  logic [XLEN-1:0]   quo, rem, dv, nq, nr, ua, ub, alu_res, sp_val, div_res;
  logic [XLEN:0]     shifted, diff;
  logic              sp, sq, sr, acc, is_mul, is_div, sgn, ovf, sp_in, ge;
  logic [SW-1:0]     sh;

  function automatic logic [XLEN-1:0] pick(input logic [2*XLEN-1:0] p, input logic [1:0] o);
    return o == 2'b00 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign acc    = in_valid && in_ready;
  assign is_mul = op[4:2] == 3'b100;
  assign is_div = op[4:2] == 3'b101;
  assign sgn    = !op[0];
  assign sh     = b[SW-1:0];

  // single-cycle ALU result
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:   alu_res = a + b;
      OP_SUB:   alu_res = a - b;
      OP_SLL:   alu_res = a << sh;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:   alu_res = a ^ b;
      OP_SRL:   alu_res = a >> sh;
      OP_SRA:   alu_res = $signed(a) >>> sh;
      OP_OR:    alu_res = a | b;
      OP_AND:   alu_res = a & b;
      OP_PASSB: alu_res = b;
      default:  alu_res = '0;
    endcase
  end

  // full-width product with per-op operand signedness, divide operand magnitudes and special cases
  always_comb begin
    prod_in = {{XLEN{(op == OP_MULH || op == OP_MULHSU) & a[XLEN-1]}}, a}
            * {{XLEN{(op == OP_MULH) & b[XLEN-1]}}, b};
    ua      = sgn && a[XLEN-1] ? -a : a;
    ub      = sgn && b[XLEN-1] ? -b : b;
    ovf     = sgn && a == MIN_NEG && &b;
    sp_in   = b == '0 || ovf;
    sp_val  = op[1] ? (ovf ? '0 : a) : (ovf ? a : '1);
  end

  // one restoring-division step on magnitudes, then sign fix of the final values
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dv};
    ge      = !diff[XLEN];
    nr      = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    nq      = {quo[XLEN-2:0], ge};
    div_res = op_lo[1] ? (sr ? -nr : nr) : (sq ? -nq : nq);
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else
      case (state)
        IDLE: state_n = !in_valid ? IDLE
                      : is_mul ? (MUL_LAT > 1 ? MUL : DONE)
                      : (is_div && !(DIV_FASTPATH != 0 && sp_in)) ? DIV : DONE;
        MUL:  state_n = cnt <= CW'(1) ? DONE : MUL;
        DIV:  state_n = cnt == '0 ? DONE : DIV;
        DONE: state_n = out_ready ? IDLE : DONE;
        default: state_n = IDLE;
      endcase
  end

  // handshake and status outputs
  always_comb begin
    in_ready  = state == IDLE && !flush;
    out_valid = state == DONE;
    busy      = state == MUL || state == DIV;
  end

  // operand capture, multiply countdown, division iteration and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      result  <= '0;
      out_tag <= '0;
      cnt     <= '0;
      op_lo   <= '0;
      prod    <= '0;
      quo     <= '0;
      rem     <= '0;
      dv      <= '0;
      sp      <= 1'b0;
      sq      <= 1'b0;
      sr      <= 1'b0;
    end else if (acc) begin
      out_tag <= in_tag;
      op_lo   <= op[1:0];
      prod    <= prod_in;
      cnt     <= is_mul ? CW'(MUL_LAT - 1) : CW'(XLEN - 1);
      quo     <= ua;
      rem     <= '0;
      dv      <= ub;
      sp      <= sp_in;
      sq      <= sgn & (a[XLEN-1] ^ b[XLEN-1]);
      sr      <= sgn & a[XLEN-1];
      result  <= is_mul ? pick(prod_in, op[1:0]) : is_div ? sp_val : alu_res;
    end else if (state == MUL) begin
      cnt <= cnt - CW'(1);
      if (cnt <= CW'(1)) result <= pick(prod, op_lo);
    end else if (state == DIV) begin
      cnt <= cnt - CW'(1);
      quo <= nq;
      rem <= nr;
      if (cnt == '0) result <= sp ? result : div_res;
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and random checks of alu_multicycle against an arithmetic reference model
module tb_alu_multicycle;
  logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [4:0]  op = 0, in_tag = 0;
  logic [31:0] a = 0, b = 0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  logic [4:0]  out_tag;
  int nvec = 0, nmis = 0;

  alu_multicycle #(.XLEN(32), .MUL_LAT(2), .TAG_W(5), .DIV_FASTPATH(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    longint p;
    logic [63:0] u;
    logic ovf;
    sx = x;
    sy = y;
    ovf = x == 32'h80000000 && y == 32'hFFFFFFFF;
    case (o)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x << y[4:0];
      5'd3:  return {31'b0, sx < sy};
      5'd4:  return {31'b0, x < y};
      5'd5:  return x ^ y;
      5'd6:  return x >> y[4:0];
      5'd7:  return sx >>> y[4:0];
      5'd8:  return x | y;
      5'd9:  return x & y;
      5'd10: return y;
      5'd16: begin p = longint'(sx) * longint'(sy); return p[31:0]; end
      5'd17: begin p = longint'(sx) * longint'(sy); return p[63:32]; end
      5'd18: begin p = longint'(sx) * longint'({32'b0, y}); return p[63:32]; end
      5'd19: begin u = {32'b0, x} * {32'b0, y}; return u[63:32]; end
      5'd20: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (ovf) return x;
        return sx / sy;
      end
      5'd21: return y == 0 ? 32'hFFFFFFFF : x / y;
      5'd22: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        return sx % sy;
      end
      5'd23: return y == 0 ? x : x % y;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o >= 16 && o <= 19) return 2;
    if (o >= 20 && o <= 23)
      return (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)) ? 1 : 33;
    return 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] t, input int stall);
    int n;
    logic held;
    logic [31:0] exp;
    exp = model(o, x, y);
    held = 1;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1; op = o; a = x; b = y; in_tag = t;
    @(posedge clk);
    #1 in_valid = 0; op = 5'($urandom); a = $urandom; b = $urandom; in_tag = 5'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    check($sformatf("latency op%0d", o), n, lat(o, x, y));
    check($sformatf("result op%0d a=%h b=%h", o, x, y), result, exp);
    check("out_tag", out_tag, t);
    if (stall > 0) begin
      in_valid = 1;
      repeat (stall) begin
        @(negedge clk);
        if (result !== exp || out_tag !== t || !out_valid || in_ready || busy) held = 0;
      end
      check("hold_stable", held, 1);
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0; in_valid = 0;
  endtask

  int ops[21] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 16, 17, 18, 19, 20, 21, 22, 23, 31};

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_out_tag", out_tag, 0);
    reset = 0;

    run_op(5'd0, 7, 5, 3, 0);
    run_op(5'd7, 32'h80000000, 4, 1, 0);
    run_op(5'd4, 1, 32'hFFFFFFFF, 2, 0);
    run_op(5'd17, 32'h80000000, 32'h80000000, 4, 0);
    run_op(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0);
    run_op(5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, 0);
    run_op(5'd20, -7, 2, 7, 0);
    run_op(5'd22, -7, 2, 8, 0);
    run_op(5'd21, 100, 7, 9, 0);
    run_op(5'd23, 100, 7, 10, 0);
    run_op(5'd20, 5, 0, 11, 0);
    run_op(5'd22, 5, 0, 12, 0);
    run_op(5'd20, 32'h80000000, 32'hFFFFFFFF, 13, 0);
    run_op(5'd22, 32'h80000000, 32'hFFFFFFFF, 14, 0);

    run_op(5'd1, 3, 10, 15, 10);
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);

    @(negedge clk);
    in_valid = 1; op = 5'd21; a = 100; b = 7; in_tag = 16;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (9) @(negedge clk);
    check("busy_in_div", busy, 1);
    flush = 1;
    #1 check("in_ready_flush", in_ready, 0);
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    check("busy_after_flush", busy, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("no_flushed_result", seen, 0);
    run_op(5'd0, 1, 1, 9, 0);

    @(negedge clk);
    in_valid = 1; op = 5'd16; a = 3; b = 4; in_tag = 17;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_mid_mul_valid", out_valid, 0);
    check("rst_mid_mul_busy", busy, 0);
    check("rst_mid_mul_result", result, 0);
    check("rst_mid_mul_tag", out_tag, 0);
    repeat (3) @(negedge clk);
    check("rst_mid_mul_no_result", out_valid, 0);

    for (int i = 0; i < 150; i++)
      run_op(5'(ops[$urandom_range(0, 20)]), pick_val(), pick_val(), 5'($urandom), $urandom_range(0, 3));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
